// File: rtl/sck_pkg.sv
// Shared types and default widths for the serial flash clock divider.
package sck_pkg;

  localparam int DIV_W_DEF = 8;
  localparam int CYC_W_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sck_div_gen.sv
// Burst-capable programmable clock divider producing the serial flash clock
// plus lead/trail edge strobes and a completion strobe for the shift logic.
module sck_div_gen
  import sck_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CYC_W = CYC_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] div,
  input  logic [CYC_W-1:0] cycles,
  input  logic             cpol,
  output logic             clk_out,
  output logic             lead,
  output logic             trail,
  output logic             busy,
  output logic             done
);

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [CYC_W-1:0]   rem_q, rem_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               cpol_q, cpol_d;
  logic               clk_d, lead_d, trail_d, busy_d, done_d;

  // Next-state logic: idle tracking of cpol, burst launch, half-period counting and abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    div_d   = div_q;
    cpol_d  = cpol_q;
    clk_d   = clk_out;
    lead_d  = 1'b0;
    trail_d = 1'b0;
    busy_d  = busy;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        clk_d  = cpol;
        cnt_d  = '0;
        busy_d = 1'b0;
        if (start && !abort) begin
          div_d  = div;
          rem_d  = cycles;
          cpol_d = cpol;
          if (cycles != '0) begin
            state_d = RUN;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          clk_d   = cpol_q;
          busy_d  = 1'b0;
          cnt_d   = '0;
          rem_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == div_q) begin
          cnt_d = '0;
          clk_d = ~clk_out;
          if (clk_out == cpol_q) begin
            lead_d = 1'b1;
          end else begin
            trail_d = 1'b1;
            rem_d   = rem_q - 1'b1;
            if (rem_q == CYC_W'(1)) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low clear.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      cpol_q  <= 1'b0;
      clk_out <= 1'b0;
      lead    <= 1'b0;
      trail   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      cpol_q  <= cpol_d;
      clk_out <= clk_d;
      lead    <= lead_d;
      trail   <= trail_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_sck_div_gen.sv
// Self-checking bench for sck_div_gen: directed scenarios plus randomized
// bursts, compared each cycle against a timeline model of the divider.
module tb_sck_div_gen;

  localparam int DIV_W = 8;
  localparam int CYC_W = 16;

  logic             clk_in = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic [CYC_W-1:0] cycles = '0;
  logic             cpol = 1'b0;
  logic             clk_out, lead, trail, busy, done;

  int checks = 0;
  int passed = 0;

  // Model: a burst is a timeline measured in edges since the start edge.
  int  edge_n = 0;
  bit  act = 1'b0;
  int  t0 = 0;
  int  md = 0;
  int  mc = 0;
  bit  mp = 1'b0;
  logic exp_clk, exp_lead, exp_trail, exp_busy, exp_done;

  sck_div_gen #(.DIV_W(DIV_W), .CYC_W(CYC_W)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .div    (div),
    .cycles (cycles),
    .cpol   (cpol),
    .clk_out(clk_out),
    .lead   (lead),
    .trail  (trail),
    .busy   (busy),
    .done   (done)
  );

  // Free-running system clock.
  always #5 clk_in = ~clk_in;

  task automatic check_bit(input string tag, input logic got, input logic want);
    checks++;
    assert (got === want) passed++;
    else $error("[TB] FAIL %s at edge %0d: got %b expected %b", tag, edge_n, got, want);
  endtask

  task automatic checkOutput();
    check_bit("clk_out", clk_out, exp_clk);
    check_bit("lead", lead, exp_lead);
    check_bit("trail", trail, exp_trail);
    check_bit("busy", busy, exp_busy);
    check_bit("done", done, exp_done);
  endtask

  // Advance the model by one edge using the inputs sampled at that edge.
  task automatic model_edge();
    int t, h, k, tend;
    edge_n++;
    exp_lead  = 1'b0;
    exp_trail = 1'b0;
    exp_done  = 1'b0;
    if (!rst) begin
      exp_clk  = 1'b0;
      exp_busy = 1'b0;
      act      = 1'b0;
    end else if (act) begin
      t    = edge_n - t0;
      h    = md + 1;
      tend = 2 * mc * h;
      if (abort) begin
        exp_clk  = mp;
        exp_busy = 1'b0;
        act      = 1'b0;
      end else begin
        k       = t / h;
        exp_clk = mp ^ (k % 2 == 1);
        if (t % h == 0) begin
          if (k % 2 == 1) exp_lead = 1'b1;
          else exp_trail = 1'b1;
        end
        if (t == tend) begin
          act      = 1'b0;
          exp_busy = 1'b0;
          exp_done = 1'b1;
        end else begin
          exp_busy = 1'b1;
        end
      end
    end else begin
      exp_clk  = cpol;
      exp_busy = 1'b0;
      if (start && !abort) begin
        md = int'(div);
        mc = int'(cycles);
        mp = cpol;
        if (cycles != '0) begin
          act      = 1'b1;
          t0       = edge_n;
          exp_busy = 1'b1;
        end else begin
          exp_done = 1'b1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit s, input bit a);
    start = s;
    abort = a;
    @(posedge clk_in);
    model_edge();
    #1;
    checkOutput();
  endtask

  task automatic run_until_idle(input int budget, input bit noise);
    int n = 0;
    while (act && n < budget) begin
      if (noise) begin
        div    = DIV_W'($urandom);
        cycles = CYC_W'($urandom);
        cpol   = 1'($urandom);
        applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
      end else begin
        applyStimulus(1'b0, 1'b0);
      end
      n++;
    end
    if (act) begin
      checks++;
      $error("[TB] FAIL burst_timeout: still running after %0d cycles, expected idle", budget);
    end
  endtask

  // Directed scenarios followed by randomized bursts, all checked every cycle.
  initial begin
    // Reset held with start asserted.
    rst = 1'b0; div = 8'd1; cycles = 16'd2;
    repeat (3) applyStimulus(1'b1, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);

    // div=1, cycles=2, cpol=0.
    div = 8'd1; cycles = 16'd2; cpol = 1'b0;
    applyStimulus(1'b1, 1'b0);
    run_until_idle(100, 1'b0);
    applyStimulus(1'b0, 1'b0);

    // cpol=1, div=0, cycles=3.
    cpol = 1'b1; div = 8'd0; cycles = 16'd3;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    run_until_idle(100, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0);

    // Mid-burst abort at E10.
    cpol = 1'b0; div = 8'd3; cycles = 16'd4;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    repeat (9) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    repeat (40) applyStimulus(1'b0, 1'b0);

    // Zero-length burst.
    cycles = 16'd0; div = 8'd2;
    applyStimulus(1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b0);

    // Abort has priority over start in idle.
    cycles = 16'd2;
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);

    // Parameter changes and start ignored mid-burst, back-to-back start in done cycle.
    div = 8'd2; cycles = 16'd2; cpol = 1'b0;
    applyStimulus(1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0);
    div = 8'd7; cycles = 16'd9; cpol = 1'b1;
    applyStimulus(1'b1, 1'b0);
    for (int n = 0; n < 50 && !exp_done; n++) applyStimulus(1'b0, 1'b0);
    cycles = 16'd1;
    applyStimulus(1'b1, 1'b0);
    run_until_idle(100, 1'b0);

    // Largest divider: half period of 256 cycles.
    div = 8'hFF; cycles = 16'd1; cpol = 1'b0;
    applyStimulus(1'b1, 1'b0);
    run_until_idle(600, 1'b0);

    // Reset in the middle of a burst.
    div = 8'd1; cycles = 16'd5;
    applyStimulus(1'b1, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);

    // Randomized bursts with input noise, stray starts and occasional aborts.
    for (int b = 0; b < 40; b++) begin
      div    = DIV_W'($urandom_range(0, 6));
      cycles = CYC_W'($urandom_range(0, 4));
      cpol   = 1'($urandom);
      applyStimulus(1'b1, 1'b0);
      run_until_idle(400, 1'b1);
      if ($urandom_range(0, 1) == 1) applyStimulus(1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
